// File: rtl/pio_in_pkg.sv
// Shared constants for the input PIO: register addresses and edge-capture modes.
package pio_in_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RAW     = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/pio_debounce.sv
// One input bit: multi-flop synchroniser followed by an optional stability-count debouncer.
module pio_debounce #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic raw,
  output logic stable
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end

  assign raw = sync_q[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign stable = raw;
    end else begin : g_count
      localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

      logic [CW-1:0] count;
      logic          stable_r;

      // Any cycle where raw agrees with the accepted value restarts the count.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          count    <= '0;
          stable_r <= 1'b0;
        end else if (raw == stable_r) begin
          count <= '0;
        end else if (count == LAST) begin
          stable_r <= raw;
          count    <= '0;
        end else begin
          count <= count + CW'(1);
        end
      end

      assign stable = stable_r;
    end
  endgenerate

endmodule

// File: rtl/pio_in_irq.sv
// Avalon-MM input PIO: synchronised/debounced inputs, sticky edge capture, maskable level irq.
module pio_in_irq
  import pio_in_pkg::*;
#(
  parameter int unsigned WIDTH           = 9,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 0,
  parameter int unsigned EDGE_TYPE       = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] raw, stable, stable_q, edges, irq_mask, edge_cap, clr;
  logic [31:0]      rd_next;
  logic             wr;
  logic             unused_wdata;

  assign unused_wdata = ^writedata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pio_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (in_port[i]),
      .raw     (raw[i]),
      .stable  (stable[i])
    );
  end

  always_comb begin
    if (EDGE_TYPE == EDGE_FALL)     edges = ~stable & stable_q;
    else if (EDGE_TYPE == EDGE_ANY) edges = stable ^ stable_q;
    else                            edges = stable & ~stable_q;
  end

  assign wr  = chipselect & ~write_n;
  assign clr = (wr && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

  // A fresh edge is OR'd in after the clear so it is never lost to a simultaneous W1C.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_q <= '0;
      irq_mask <= '0;
      edge_cap <= '0;
    end else begin
      stable_q <= stable;
      edge_cap <= (edge_cap & ~clr) | edges;
      if (wr && address == ADDR_IRQMASK) irq_mask <= writedata[WIDTH-1:0];
    end
  end

  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_DATA:    rd_next[WIDTH-1:0] = stable;
      ADDR_RAW:     rd_next[WIDTH-1:0] = raw;
      ADDR_IRQMASK: rd_next[WIDTH-1:0] = irq_mask;
      ADDR_EDGECAP: rd_next[WIDTH-1:0] = edge_cap;
      default:      rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_next;
  end

  assign irq = |(edge_cap & irq_mask);

endmodule

// File: doc/pio_in_irq.md
# pio_in_irq

Parametrised Avalon-MM input PIO slave, successor to the fixed 9-bit read-only switch port. Synchronises and debounces a WIDTH-bit external input bus, latches configurable edges into a sticky edge-capture register, and raises a maskable level interrupt to the Nios II processor. It sits on the system interconnect next to the other PIO peripherals and keeps the standard PIO register map, so existing HAL drivers work unchanged.

## Interface
Parameters:
- WIDTH, 9, number of input bits (1..32)
- SYNC_STAGES, 2, synchroniser flops per bit (>=2)
- DEBOUNCE_CYCLES, 0, consecutive stable cycles required before accepting a change; 0 = bypass
- EDGE_TYPE, 0, capture mode: 0 rising, 1 falling, 2 any edge

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  2  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  registered read data
- in_port  in  WIDTH  asynchronous external inputs
- irq  out  1  level interrupt

## Operation
- Register map: 0 DATA (RO, debounced value); 1 RAW (RO, synchronised pre-debounce value); 2 IRQMASK (RW, WIDTH bits); 3 EDGECAPTURE (RW1C).
- Upper readdata bits [31:WIDTH] always 0. Writes to addresses 0/1 ignored.
- Write = chipselect & !write_n. IRQMASK <= writedata[WIDTH-1:0]. EDGECAPTURE bit i cleared where writedata[i]=1.
- Per bit: SYNC_STAGES-flop synchroniser -> debouncer -> stable value.
- Debouncer: counter of width clog2(DEBOUNCE_CYCLES+1). sync == stable: counter <= 0. Mismatch: counter increments; on mismatch with counter == DEBOUNCE_CYCLES-1, stable <= sync, counter <= 0. A bounce (sync returns to stable) restarts the count.
- Edge detect: stable_q = stable delayed 1 cycle. rise = stable & ~stable_q, fall = ~stable & stable_q; selected per EDGE_TYPE. A detected edge sets its EDGECAPTURE bit (sticky).
- Same-cycle edge detect and clear on one bit: set wins, bit stays 1.
- irq = |(EDGECAPTURE & IRQMASK), combinational from flops only.
- readdata <= register selected by address every cycle; chipselect not required for read (matches existing PIO behaviour).

## Timing
- Reset: readdata, IRQMASK, EDGECAPTURE, sync chains, stable, stable_q, counters all 0; irq 0. Reset mid-debounce discards the count; no edge is reported from the reset release itself.
- Read latency: 1 cycle (address at edge N -> readdata valid after edge N).
- in_port change set up before edge E0: RAW visible in sync output after E(SYNC_STAGES-1); stable after E(SYNC_STAGES-1+DEBOUNCE_CYCLES); EDGECAPTURE bit and irq after E(SYNC_STAGES+DEBOUNCE_CYCLES); DATA readable with one further cycle of read latency.
- Pulses shorter than DEBOUNCE_CYCLES cycles (after sync) are rejected; with bypass, any pulse held >=1 cycle through the synchroniser is captured.
- IRQMASK write takes effect on irq the cycle after the write edge; EDGECAPTURE clear drops irq the cycle after unless a new edge sets it.

## Structure
- Package pio_in_pkg: address constants (ADDR_DATA=0, ADDR_RAW=1, ADDR_IRQMASK=2, ADDR_EDGECAP=3), edge-type encoding (EDGE_RISE, EDGE_FALL, EDGE_ANY).
- Sub-module pio_debounce: one bit, synchroniser + counter + stable output, parametrised by SYNC_STAGES and DEBOUNCE_CYCLES; top instantiates WIDTH copies via generate.

## Test plan
- Reset then read all four addresses with in_port=9'h000 -> readdata 0 each, irq 0.
- DEBOUNCE_CYCLES=0, EDGE_TYPE=0: IRQMASK=9'h001, drive in_port 0->9'h001 -> EDGECAPTURE=1 and irq=1 exactly SYNC_STAGES cycles later; DATA reads 32'h1.
- DEBOUNCE_CYCLES=4: toggle bit 3 high 3 cycles then low -> no DATA change, EDGECAPTURE 0; hold high 4 cycles -> DATA bit 3 set, EDGECAPTURE bit 3 set.
- EDGE_TYPE=2: pulse bit 5 high then low, clear EDGECAPTURE between -> both edges captured; write 32'h20 to addr 3 in same cycle as second edge -> bit 5 remains 1.
- Masking: EDGECAPTURE=9'h100, IRQMASK=0 -> irq 0; write IRQMASK=9'h100 -> irq 1 next cycle; write 32'h100 to addr 3 -> irq 0 next cycle.
- Assert reset_n low mid-debounce with counter=2 -> all outputs 0 immediately; after release with in_port held 9'h1FF, DATA reaches 9'h1FF after full latency, edges captured as new rising edges.
